// File: rtl/video_pkg.sv
// Shared types and widths for the video source switch.
package video_pkg;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned LINE_W = 12;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PEND  = 2'd1,
    ST_ALIGN = 2'd2
  } state_t;

endpackage

// File: rtl/video_line_check.sv
// Counts data-enable cycles per line and flags lines whose length differs from H_DISP.
module video_line_check
  import video_pkg::*;
#(
  parameter int unsigned H_DISP = 1280
) (
  input  logic clk,
  input  logic rst_n,
  input  logic de,
  output logic err
);

  localparam logic [LINE_W-1:0] CNT_MAX = '1;

  logic [LINE_W-1:0] r_cnt;
  logic              r_de_d;
  logic              r_err;

  // Saturating count while de is high; judge and clear on the falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_de_d <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_de_d <= de;
      r_err  <= 1'b0;
      if (de) begin
        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + LINE_W'(1);
      end else if (r_de_d) begin
        r_err <= (r_cnt != LINE_W'(H_DISP));
        r_cnt <= '0;
      end
    end
  end

  assign err = r_err;

endmodule

// File: rtl/video_src_switch.sv
// Frame-aligned video source switch: changes channel only at vsync boundaries,
// blanking the output between the old channel's frame start and the new one's.
module video_src_switch
  import video_pkg::*;
#(
  parameter int unsigned CH_NUM      = 2,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned H_DISP      = 1280,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [CH_NUM-1:0]        ch_vs,
  input  logic [CH_NUM-1:0]        ch_de,
  input  logic [CH_NUM*DATA_W-1:0] ch_data,
  input  logic                     sel_valid,
  input  logic [SEL_W-1:0]         sel_idx,
  output logic                     out_vs,
  output logic                     out_de,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         cur_sel,
  output logic                     busy,
  output logic                     sel_err,
  output logic                     line_err,
  output logic [15:0]              frame_cnt
);

  localparam int unsigned TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_t              r_state;
  logic [SEL_W-1:0]    r_cur_sel;
  logic [SEL_W-1:0]    r_pend_sel;
  logic                r_hold;
  logic [TO_W-1:0]     r_to_cnt;
  logic [CH_NUM-1:0]   r_vs_d;
  logic                r_out_vs;
  logic                r_out_de;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_vs_d;
  logic                r_busy;
  logic                r_sel_err;
  logic [15:0]         r_frame_cnt;

  logic                w_sel_vs;
  logic                w_sel_vs_prev;
  logic                w_sel_de;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_vs_rise;
  logic                w_req_ok;
  logic                w_req_bad;
  logic [SEL_W-1:0]    w_next_pend;
  logic                w_timeout;

  // Mux of the channel addressed by cur_sel, plus its previous vsync sample.
  always_comb begin
    w_sel_vs      = 1'b0;
    w_sel_vs_prev = 1'b0;
    w_sel_de      = 1'b0;
    w_sel_data    = '0;
    for (int k = 0; k < int'(CH_NUM); k++) begin
      if (r_cur_sel == SEL_W'(k)) begin
        w_sel_vs      = ch_vs[k];
        w_sel_vs_prev = r_vs_d[k];
        w_sel_de      = ch_de[k];
        w_sel_data    = ch_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign w_vs_rise   = w_sel_vs & ~w_sel_vs_prev;
  assign w_req_ok    = sel_valid && (32'(sel_idx) < CH_NUM);
  assign w_req_bad   = sel_valid && !w_req_ok;
  assign w_next_pend = w_req_ok ? sel_idx : r_pend_sel;
  assign w_timeout   = (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_cur_sel   <= '0;
      r_pend_sel  <= '0;
      r_hold      <= 1'b0;
      r_to_cnt    <= '0;
      r_vs_d      <= '0;
      r_out_vs    <= 1'b0;
      r_out_de    <= 1'b0;
      r_out_data  <= '0;
      r_out_vs_d  <= 1'b0;
      r_busy      <= 1'b0;
      r_sel_err   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_vs_d     <= ch_vs;
      r_sel_err  <= w_req_bad;
      r_out_vs_d <= r_out_vs;
      if (r_out_vs && !r_out_vs_d) r_frame_cnt <= r_frame_cnt + 16'd1;

      case (r_state)
        ST_RUN: begin
          r_out_vs   <= w_sel_vs;
          r_out_de   <= w_sel_de;
          r_out_data <= w_sel_data;
          r_hold     <= 1'b0;
          // A fresh request supersedes one held over from ALIGN.
          if (w_req_ok) begin
            if (sel_idx != r_cur_sel) begin
              r_pend_sel <= sel_idx;
              r_to_cnt   <= '0;
              r_busy     <= 1'b1;
              r_state    <= ST_PEND;
            end
          end else if (r_hold && (r_pend_sel != r_cur_sel)) begin
            r_to_cnt <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_PEND;
          end
        end

        ST_PEND: begin
          r_pend_sel <= w_next_pend;
          if (w_vs_rise || w_timeout) begin
            r_cur_sel  <= w_next_pend;
            r_out_vs   <= 1'b0;
            r_out_de   <= 1'b0;
            r_out_data <= '0;
            r_state    <= ST_ALIGN;
          end else begin
            r_out_vs   <= w_sel_vs;
            r_out_de   <= w_sel_de;
            r_out_data <= w_sel_data;
            r_to_cnt   <= r_to_cnt + TO_W'(1);
          end
        end

        ST_ALIGN: begin
          if (w_req_ok) begin
            r_pend_sel <= sel_idx;
            r_hold     <= 1'b1;
          end
          // The new channel's frame-start cycle is forwarded, not swallowed.
          if (w_vs_rise) begin
            r_out_vs   <= w_sel_vs;
            r_out_de   <= w_sel_de;
            r_out_data <= w_sel_data;
            r_busy     <= 1'b0;
            r_state    <= ST_RUN;
          end else begin
            r_out_vs   <= 1'b0;
            r_out_de   <= 1'b0;
            r_out_data <= '0;
          end
        end

        default: begin
          r_state <= ST_RUN;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  video_line_check #(
    .H_DISP (H_DISP)
  ) u_line_check (
    .clk   (clk),
    .rst_n (rst_n),
    .de    (r_out_de),
    .err   (line_err)
  );

  assign out_vs    = r_out_vs;
  assign out_de    = r_out_de;
  assign out_data  = r_out_data;
  assign cur_sel   = r_cur_sel;
  assign busy      = r_busy;
  assign sel_err   = r_sel_err;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_video_src_switch.sv
// Directed self-checking bench for video_src_switch (3 channels, 100-cycle timeout).
module tb_video_src_switch;

  localparam int unsigned CH = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned HD = 1280;
  localparam int unsigned TO = 100;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [CH-1:0]   ch_vs;
  logic [CH-1:0]   ch_de;
  logic [CH*DW-1:0] ch_data;
  logic            sel_valid;
  logic [2:0]      sel_idx;
  logic            out_vs;
  logic            out_de;
  logic [DW-1:0]   out_data;
  logic [2:0]      cur_sel;
  logic            busy;
  logic            sel_err;
  logic            line_err;
  logic [15:0]     frame_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  video_src_switch #(
    .CH_NUM      (CH),
    .DATA_W      (DW),
    .H_DISP      (HD),
    .TIMEOUT_CYC (TO)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_vs     (ch_vs),
    .ch_de     (ch_de),
    .ch_data   (ch_data),
    .sel_valid (sel_valid),
    .sel_idx   (sel_idx),
    .out_vs    (out_vs),
    .out_de    (out_de),
    .out_data  (out_data),
    .cur_sel   (cur_sel),
    .busy      (busy),
    .sel_err   (sel_err),
    .line_err  (line_err),
    .frame_cnt (frame_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic v, input logic d, input logic [DW-1:0] px);
    ch_vs[k]            = v;
    ch_de[k]            = d;
    ch_data[k*DW +: DW] = px;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sel_valid = 1'b0;
    sel_idx = 3'd0;
    ch_vs = '1;
    ch_de = '1;
    ch_data = '1;
    tick();
    checks++; if (out_vs !== 1'b0) begin errors++; $display("FAIL rst_out_vs got %b exp 0", out_vs); end
    checks++; if (out_de !== 1'b0) begin errors++; $display("FAIL rst_out_de got %b exp 0", out_de); end
    checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    checks++; if (cur_sel !== 3'd0 || busy !== 1'b0 || sel_err !== 1'b0 || line_err !== 1'b0)
      begin errors++; $display("FAIL rst_ctrl got sel=%0d busy=%b serr=%b lerr=%b exp 0", cur_sel, busy, sel_err, line_err); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt got %0d exp 0", frame_cnt); end
    ch_vs = '0;
    ch_de = '0;
    ch_data = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_passthrough();
    set_ch(0, 1'b0, 1'b1, 16'h1234);
    set_ch(1, 1'b1, 1'b1, 16'hBEEF);
    tick();
    checks++; if (out_data !== 16'h1234 || out_de !== 1'b1 || out_vs !== 1'b0)
      begin errors++; $display("FAIL pass_1 got vs=%b de=%b d=%h exp vs=0 de=1 d=1234", out_vs, out_de, out_data); end
    set_ch(0, 1'b1, 1'b0, 16'h0F0F);
    set_ch(1, 1'b0, 1'b0, 16'h0000);
    tick();
    checks++; if (out_data !== 16'h0F0F || out_de !== 1'b0 || out_vs !== 1'b1)
      begin errors++; $display("FAIL pass_2 got vs=%b de=%b d=%h exp vs=1 de=0 d=0f0f", out_vs, out_de, out_data); end
    set_ch(0, 1'b0, 1'b0, 16'h0000);
    tick();
    checks++; if (out_vs !== 1'b0 || frame_cnt !== 16'd1)
      begin errors++; $display("FAIL pass_frame got vs=%b fc=%0d exp vs=0 fc=1", out_vs, frame_cnt); end
  endtask

  task automatic test_invalid_sel();
    sel_valid = 1'b1;
    sel_idx = 3'd5;
    tick();
    sel_valid = 1'b0;
    checks++; if (sel_err !== 1'b1 || busy !== 1'b0 || cur_sel !== 3'd0)
      begin errors++; $display("FAIL bad5 got serr=%b busy=%b sel=%0d exp 1 0 0", sel_err, busy, cur_sel); end
    tick();
    checks++; if (sel_err !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL bad5_pulse got serr=%b busy=%b exp 0 0", sel_err, busy); end
    sel_valid = 1'b1;
    sel_idx = 3'd3;
    tick();
    sel_valid = 1'b0;
    checks++; if (sel_err !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL bad3 got serr=%b busy=%b exp 1 0", sel_err, busy); end
    sel_valid = 1'b1;
    sel_idx = 3'd0;
    tick();
    sel_valid = 1'b0;
    checks++; if (sel_err !== 1'b0 || busy !== 1'b0)
      begin errors++; $display("FAIL same_idx got serr=%b busy=%b exp 0 0", sel_err, busy); end
    tick();
    checks++; if (busy !== 1'b0 || cur_sel !== 3'd0)
      begin errors++; $display("FAIL same_idx_hold got busy=%b sel=%0d exp 0 0", busy, cur_sel); end
  endtask

  task automatic test_switch();
    set_ch(0, 1'b0, 1'b1, 16'h1111);
    sel_valid = 1'b1;
    sel_idx = 3'd1;
    tick();
    sel_valid = 1'b0;
    checks++; if (busy !== 1'b1 || cur_sel !== 3'd0 || out_data !== 16'h1111)
      begin errors++; $display("FAIL sw_req got busy=%b sel=%0d d=%h exp 1 0 1111", busy, cur_sel, out_data); end
    set_ch(0, 1'b0, 1'b1, 16'h2222);
    set_ch(1, 1'b0, 1'b1, 16'h9999);
    tick();
    checks++; if (out_data !== 16'h2222 || busy !== 1'b1)
      begin errors++; $display("FAIL sw_pend got d=%h busy=%b exp 2222 1", out_data, busy); end
    set_ch(0, 1'b1, 1'b0, 16'h3333);
    tick();
    checks++; if (cur_sel !== 3'd1 || out_vs !== 1'b0 || out_data !== 16'h0 || busy !== 1'b1)
      begin errors++; $display("FAIL sw_align got sel=%0d vs=%b d=%h busy=%b exp 1 0 0 1", cur_sel, out_vs, out_data, busy); end
    set_ch(0, 1'b0, 1'b0, 16'h0000);
    set_ch(1, 1'b0, 1'b1, 16'h9998);
    tick();
    checks++; if (out_de !== 1'b0 || out_data !== 16'h0 || busy !== 1'b1)
      begin errors++; $display("FAIL sw_blank got de=%b d=%h busy=%b exp 0 0 1", out_de, out_data, busy); end
    set_ch(1, 1'b1, 1'b0, 16'hA001);
    tick();
    checks++; if (out_vs !== 1'b1 || out_data !== 16'hA001 || busy !== 1'b0 || cur_sel !== 3'd1)
      begin errors++; $display("FAIL sw_run got vs=%b d=%h busy=%b sel=%0d exp 1 a001 0 1", out_vs, out_data, busy, cur_sel); end
    set_ch(1, 1'b0, 1'b1, 16'hA002);
    tick();
    checks++; if (out_de !== 1'b1 || out_data !== 16'hA002 || frame_cnt !== 16'd2)
      begin errors++; $display("FAIL sw_follow got de=%b d=%h fc=%0d exp 1 a002 2", out_de, out_data, frame_cnt); end
    set_ch(1, 1'b0, 1'b0, 16'h0000);
    tick();
  endtask

  task automatic test_timeout();
    set_ch(1, 1'b0, 1'b0, 16'h5555);
    sel_valid = 1'b1;
    sel_idx = 3'd0;
    tick();
    sel_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_req got busy=%b exp 1", busy); end
    repeat (TO - 1) tick();
    checks++; if (cur_sel !== 3'd1 || busy !== 1'b1 || out_data !== 16'h5555)
      begin errors++; $display("FAIL to_early got sel=%0d busy=%b d=%h exp 1 1 5555", cur_sel, busy, out_data); end
    tick();
    checks++; if (cur_sel !== 3'd0 || busy !== 1'b1 || out_data !== 16'h0)
      begin errors++; $display("FAIL to_align got sel=%0d busy=%b d=%h exp 0 1 0", cur_sel, busy, out_data); end
    set_ch(0, 1'b1, 1'b0, 16'h7777);
    tick();
    checks++; if (out_vs !== 1'b1 || busy !== 1'b0 || out_data !== 16'h7777)
      begin errors++; $display("FAIL to_run got vs=%b busy=%b d=%h exp 1 0 7777", out_vs, busy, out_data); end
    set_ch(0, 1'b0, 1'b0, 16'h0000);
    set_ch(1, 1'b0, 1'b0, 16'h0000);
    tick();
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL to_frame got %0d exp 3", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    set_ch(2, 1'b0, 1'b0, 16'hC000);
    sel_valid = 1'b1;
    sel_idx = 3'd1;
    tick();
    checks++; if (busy !== 1'b1 || cur_sel !== 3'd0)
      begin errors++; $display("FAIL b2b_req1 got busy=%b sel=%0d exp 1 0", busy, cur_sel); end
    sel_idx = 3'd2;
    set_ch(0, 1'b1, 1'b0, 16'h0000);
    tick();
    sel_valid = 1'b0;
    checks++; if (cur_sel !== 3'd2 || busy !== 1'b1 || out_vs !== 1'b0)
      begin errors++; $display("FAIL b2b_newest got sel=%0d busy=%b vs=%b exp 2 1 0", cur_sel, busy, out_vs); end
    set_ch(0, 1'b0, 1'b0, 16'h0000);
    sel_valid = 1'b1;
    sel_idx = 3'd0;
    tick();
    sel_valid = 1'b0;
    checks++; if (cur_sel !== 3'd2 || busy !== 1'b1 || out_data !== 16'h0)
      begin errors++; $display("FAIL b2b_align_req got sel=%0d busy=%b d=%h exp 2 1 0", cur_sel, busy, out_data); end
    set_ch(2, 1'b1, 1'b0, 16'hC001);
    tick();
    checks++; if (busy !== 1'b0 || cur_sel !== 3'd2 || out_vs !== 1'b1 || out_data !== 16'hC001)
      begin errors++; $display("FAIL b2b_run got busy=%b sel=%0d vs=%b d=%h exp 0 2 1 c001", busy, cur_sel, out_vs, out_data); end
    set_ch(2, 1'b0, 1'b0, 16'hC002);
    tick();
    checks++; if (busy !== 1'b1 || out_data !== 16'hC002 || frame_cnt !== 16'd4)
      begin errors++; $display("FAIL b2b_held got busy=%b d=%h fc=%0d exp 1 c002 4", busy, out_data, frame_cnt); end
    set_ch(2, 1'b1, 1'b0, 16'hC003);
    tick();
    checks++; if (cur_sel !== 3'd0 || out_data !== 16'h0 || busy !== 1'b1)
      begin errors++; $display("FAIL b2b_align2 got sel=%0d d=%h busy=%b exp 0 0 1", cur_sel, out_data, busy); end
  endtask

  task automatic test_reset_in_align();
    set_ch(2, 1'b0, 1'b0, 16'h0000);
    set_ch(0, 1'b0, 1'b1, 16'hD00D);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_vs !== 1'b0 || out_de !== 1'b0 || out_data !== 16'h0 || busy !== 1'b0 || cur_sel !== 3'd0 || frame_cnt !== 16'd0)
      begin errors++; $display("FAIL rst_async got vs=%b de=%b d=%h busy=%b sel=%0d fc=%0d exp all 0", out_vs, out_de, out_data, busy, cur_sel, frame_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (out_data !== 16'hD00D || out_de !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL rst_follow got d=%h de=%b busy=%b exp d00d 1 0", out_data, out_de, busy); end
    set_ch(0, 1'b0, 1'b1, 16'hD00E);
    tick();
    checks++; if (out_data !== 16'hD00E) begin errors++; $display("FAIL rst_follow2 got %h exp d00e", out_data); end
    set_ch(0, 1'b0, 1'b0, 16'h0000);
    repeat (4) tick();
  endtask

  task automatic test_line_len();
    int pulses;
    for (int len = HD - 1; len <= int'(HD); len++) begin
      set_ch(0, 1'b0, 1'b1, 16'h00AA);
      repeat (len) tick();
      set_ch(0, 1'b0, 1'b0, 16'h0000);
      pulses = 0;
      repeat (4) begin
        tick();
        if (line_err === 1'b1) pulses++;
      end
      checks++;
      if (pulses !== ((len == int'(HD)) ? 0 : 1))
        begin errors++; $display("FAIL line_len_%0d got %0d pulses exp %0d", len, pulses, (len == int'(HD)) ? 0 : 1); end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_invalid_sel();
    test_switch();
    test_timeout();
    test_back_to_back();
    test_reset_in_align();
    test_line_len();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/video_src_switch.md
VIDEO_SRC_SWITCH -- requirements
Module: video_src_switch

Interface
REQ-001 SHALL have parameter CH_NUM, default 2, number of input video channels (2..8).
REQ-002 SHALL have parameter DATA_W, default 16, pixel width (RGB565).
REQ-003 SHALL have parameter H_DISP, default 1280, expected active pixels per line.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 2000000, maximum wait for frame boundary on the old channel.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all ports are synchronous to it.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port ch_vs, input, CH_NUM bits: per-channel vsync, active high.
REQ-008 SHALL have port ch_de, input, CH_NUM bits: per-channel data enable.
REQ-009 SHALL have port ch_data, input, CH_NUM*DATA_W bits: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port sel_valid, input, 1 bit: one-cycle switch request strobe.
REQ-011 SHALL have port sel_idx, input, 3 bits: requested channel.
REQ-012 SHALL have port out_vs, output, 1 bit: switched vsync.
REQ-013 SHALL have port out_de, output, 1 bit: switched data enable.
REQ-014 SHALL have port out_data, output, DATA_W bits: switched pixel data.
REQ-015 SHALL have port cur_sel, output, 3 bits: channel currently driving the output.
REQ-016 SHALL have port busy, output, 1 bit: high while a switch is pending or aligning.
REQ-017 SHALL have port sel_err, output, 1 bit: one-cycle pulse flagging a rejected request.
REQ-018 SHALL have port line_err, output, 1 bit: one-cycle pulse flagging a wrong line length.
REQ-019 SHALL have port frame_cnt, output, 16 bits: count of output frames.

Function
REQ-020 SHALL register out_vs/out_de/out_data one cycle after the selected channel's inputs (latency 1) in state RUN.
REQ-021 SHALL implement states RUN, PEND, ALIGN; the reset state is RUN with cur_sel=0.
REQ-022 SHALL treat sel_valid with sel_idx>=CH_NUM as rejected: sel_err pulses the next cycle and no state change occurs.
REQ-023 SHALL ignore, without error, a sel_valid in RUN whose sel_idx equals cur_sel.
REQ-024 SHALL, in RUN, latch sel_idx into pend_sel on a valid request and enter PEND the next cycle.
REQ-025 SHALL, in PEND, keep passing the old channel and overwrite pend_sel with any newer valid request.
REQ-026 SHALL leave PEND for ALIGN on the cycle after a rising edge of the old channel's vs, or when the timeout counter reaches TIMEOUT_CYC-1; on that transition cur_sel becomes pend_sel.
REQ-027 SHALL, in ALIGN, drive out_vs=0, out_de=0 and out_data=0.
REQ-028 SHALL leave ALIGN for RUN on a rising edge of the new channel's vs, with that vs-high cycle forwarded as the first output cycle (no lost frame start).
REQ-029 SHALL hold a valid request arriving in ALIGN in pend_sel and enter PEND from RUN on the cycle after reaching RUN.
REQ-030 SHALL process sel_valid before the vs edge when both occur in the same PEND cycle (the newest index wins).
REQ-031 SHALL increment frame_cnt on every rising edge of out_vs, wrapping 0xFFFF to 0.
REQ-032 SHALL count out_de-high cycles per line (counter saturating at 4095) and pulse line_err on the falling edge of out_de when the count is not equal to H_DISP; the counter clears after each line.
REQ-033 SHALL drive busy high exactly while in PEND or ALIGN.

Reset
REQ-034 SHALL, while rst_n is low, force out_vs=0, out_de=0, out_data=0, cur_sel=0, busy=0, sel_err=0, line_err=0, frame_cnt=0, pend_sel=0, clear the timeout and line counters, and set state to RUN.
REQ-035 SHALL abandon any pending switch on reset mid-operation.

Structure
REQ-036 SHALL place the state encoding, the 3-bit select width and the 12-bit line-counter width in shared package video_pkg.
REQ-037 SHALL implement the line-length checker as sub-module video_line_check (inputs clk, rst_n, de; output err).

Verification
REQ-038 SHALL cover this scenario: with CH_NUM=2 and ch0 streaming, sel_idx=1 is requested mid-frame -> busy=1, output follows ch0 until the ch0 vs rise, then is blanked until the ch1 vs rise, cur_sel=1, and busy=0.
REQ-039 SHALL cover this scenario: sel_idx=5 is requested with CH_NUM=2 -> sel_err pulses for 1 cycle, cur_sel stays 0, and busy stays 0.
REQ-040 SHALL cover this scenario: ch0 vs held low with TIMEOUT_CYC=100 and a switch to 1 requested -> ALIGN is entered 100 cycles after the request.
REQ-041 SHALL cover this scenario: 3-channel configuration, requests for 1 then 2 while in PEND -> the final cur_sel is 2 and only one ALIGN phase occurs.
REQ-042 SHALL cover this scenario: a line of 1279 de cycles with H_DISP=1280 -> line_err pulses once; a 1280-cycle line -> no pulse.
REQ-043 SHALL cover this scenario: rst_n asserted during ALIGN -> all outputs are 0 immediately; after release, output follows ch0 with 1-cycle latency.
